// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths and the issue payload type for the operand-fetch
//            stage.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 8;

  // Everything execute needs for one instruction, held in a single register.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] dst;
    logic              dst_wr;
  } issue_t;

endpackage
`default_nettype wire

// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_if
// Brief    : Decode, register-file, writeback and issue signals of the
//            operand-fetch stage. slave = the stage, master = its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface operand_fetch_if
  import cpu_pkg::*;
  ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [REG_AW-1:0] in_src1;
  logic [REG_AW-1:0] in_src2;
  logic [REG_AW-1:0] in_dst;
  logic              in_dst_wr;

  logic [REG_AW-1:0] rf_rd1;
  logic [REG_AW-1:0] rf_rd2;
  logic [DATA_W-1:0] rf_rd1_data;
  logic [DATA_W-1:0] rf_rd2_data;

  logic              wb_wr;
  logic [REG_AW-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [REG_AW-1:0] out_dst;
  logic              out_dst_wr;

  logic              flush;
  logic              stall;

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_dst, in_dst_wr,
    input  rf_rd1_data, rf_rd2_data,
    input  wb_wr, wb_dst, wb_data,
    input  out_ready, flush,
    output in_ready, rf_rd1, rf_rd2,
    output out_valid, out_op, out_a, out_b, out_dst, out_dst_wr,
    output stall
  );

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_dst, in_dst_wr,
    output rf_rd1_data, rf_rd2_data,
    output wb_wr, wb_dst, wb_data,
    output out_ready, flush,
    input  in_ready, rf_rd1, rf_rd2,
    input  out_valid, out_op, out_a, out_b, out_dst, out_dst_wr,
    input  stall
  );

endinterface
`default_nettype wire

// File: rtl/of_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : of_scoreboard
// Brief    : Pending-write vector with set / writeback-clear / flush-clear and
//            per-port hazard lookups that see through a same-cycle writeback.
// Revision : 1.0 - initial release
// ============================================================================
module of_scoreboard
  import cpu_pkg::*;
  (
  input  wire              clk,
  input  wire              rst,
  input  wire              set_en,
  input  wire [REG_AW-1:0] set_idx,
  input  wire              wb_wr,
  input  wire [REG_AW-1:0] wb_dst,
  input  wire              kill_en,
  input  wire [REG_AW-1:0] kill_idx,
  input  wire [REG_AW-1:0] src1,
  input  wire [REG_AW-1:0] src2,
  input  wire [REG_AW-1:0] dst,
  output logic             hz_src1,
  output logic             hz_src2,
  output logic             hz_dst
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;

  // Clears first, set last, so a same-cycle set on the same register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_wr)   w_pending_nxt[wb_dst]   = 1'b0;
    if (kill_en) w_pending_nxt[kill_idx] = 1'b0;
    if (set_en)  w_pending_nxt[set_idx]  = 1'b1;
  end

  // Pending vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  // A register being written back this cycle is forwarded, so it is no hazard.
  always_comb begin
    hz_src1 = r_pending[src1] & ~(wb_wr & (wb_dst == src1));
    hz_src2 = r_pending[src2] & ~(wb_wr & (wb_dst == src2));
    hz_dst  = r_pending[dst]  & ~(wb_wr & (wb_dst == dst));
  end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Brief    : Reads operands with writeback forwarding, blocks on RAW/WAW
//            hazards through the scoreboard and holds a one-entry issue
//            register toward execute.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch
  import cpu_pkg::*;
  (
  input wire               clk,
  input wire               rst,
  operand_fetch_if.slave   bus
);

  issue_t      r_payload;
  issue_t      w_payload_nxt;
  logic        r_out_valid;
  logic        w_hz_src1;
  logic        w_hz_src2;
  logic        w_hz_dst;
  logic        w_hazard;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_kill;

  of_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (w_accept & bus.in_dst_wr),
    .set_idx  (bus.in_dst),
    .wb_wr    (bus.wb_wr),
    .wb_dst   (bus.wb_dst),
    .kill_en  (w_kill),
    .kill_idx (r_payload.dst),
    .src1     (bus.in_src1),
    .src2     (bus.in_src2),
    .dst      (bus.in_dst),
    .hz_src1  (w_hz_src1),
    .hz_src2  (w_hz_src2),
    .hz_dst   (w_hz_dst)
  );

  // Handshake: hazard, flush and a blocked output register all hold decode.
  always_comb begin
    w_hazard   = w_hz_src1 | w_hz_src2 | (bus.in_dst_wr & w_hz_dst);
    w_in_ready = rst | (~w_hazard & ~bus.flush & (~r_out_valid | bus.out_ready));
    w_accept   = ~rst & bus.in_valid & w_in_ready;
    w_kill     = bus.flush & r_out_valid & r_payload.dst_wr;
  end

  // Next payload with forwarding of a same-cycle writeback.
  always_comb begin
    w_payload_nxt.op     = bus.in_op;
    w_payload_nxt.a      = (bus.wb_wr && bus.wb_dst == bus.in_src1) ? bus.wb_data : bus.rf_rd1_data;
    w_payload_nxt.b      = (bus.wb_wr && bus.wb_dst == bus.in_src2) ? bus.wb_data : bus.rf_rd2_data;
    w_payload_nxt.dst    = bus.in_dst;
    w_payload_nxt.dst_wr = bus.in_dst_wr;
  end

  // Issue register: load on accept, drop on flush or consumption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_payload   <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_payload   <= w_payload_nxt;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Output drive.
  always_comb begin
    bus.in_ready   = w_in_ready;
    bus.stall      = ~rst & bus.in_valid & w_hazard;
    bus.rf_rd1     = bus.in_src1;
    bus.rf_rd2     = bus.in_src2;
    bus.out_valid  = r_out_valid;
    bus.out_op     = r_payload.op;
    bus.out_a      = r_payload.a;
    bus.out_b      = r_payload.b;
    bus.out_dst    = r_payload.dst;
    bus.out_dst_wr = r_payload.dst_wr;
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Brief    : Directed self-checking bench for operand_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [31:0] rf [16];

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational register-file model.
  assign bus.rf_rd1_data = rf[bus.rf_rd1];
  assign bus.rf_rd2_data = rf[bus.rf_rd2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] d, input logic dw);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_src1   = s1;
    bus.in_src2   = s2;
    bus.in_dst    = d;
    bus.in_dst_wr = dw;
  endtask

  task automatic wb(input logic w, input logic [3:0] d, input logic [31:0] data);
    bus.wb_wr   = w;
    bus.wb_dst  = d;
    bus.wb_data = data;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h100 + i;
    rf[2] = 32'hA;
    rf[3] = 32'hB;
    rf[5] = 32'h55;
    drive(1'b1, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    wb(1'b0, 4'd0, 32'd0);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    rst = 1'b1;
    tick();
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_out_a", bus.out_a, 32'd0);
    rst = 1'b0;
    bus.flush = 1'b0;
    tick();

    // Basic issue with register-file operands.
    drive(1'b1, 8'h11, 4'd2, 4'd3, 4'd1, 1'b0);
    #1;
    check("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t1_rf_rd1", {28'd0, bus.rf_rd1}, 32'd2);
    tick();
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    check("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t1_out_op", {24'd0, bus.out_op}, 32'h11);
    check("t1_out_a", bus.out_a, 32'hA);
    check("t1_out_b", bus.out_b, 32'hB);
    tick();
    check("t1_drain", {31'd0, bus.out_valid}, 32'd0);

    // RAW hazard on r5, resolved by a forwarded writeback.
    drive(1'b1, 8'h22, 4'd0, 4'd0, 4'd5, 1'b1);
    tick();
    drive(1'b1, 8'h33, 4'd5, 4'd0, 4'd0, 1'b0);
    #1;
    check("t2_stall", {31'd0, bus.stall}, 32'd1);
    check("t2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("t2_stall_hold", {31'd0, bus.stall}, 32'd1);
    wb(1'b1, 4'd5, 32'hDEAD);
    #1;
    check("t2_wb_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t2_wb_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    wb(1'b0, 4'd0, 32'd0);
    rf[5] = 32'hDEAD;
    check("t2_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t2_out_a", bus.out_a, 32'hDEAD);
    check("t2_out_op", {24'd0, bus.out_op}, 32'h33);

    // Backpressure holds the payload, then back-to-back transfer.
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h44, 4'd2, 4'd3, 4'd0, 1'b0);
    #1;
    check("t3_blocked", {31'd0, bus.in_ready}, 32'd0);
    check("t3_no_stall", {31'd0, bus.stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t3_hold_op", {24'd0, bus.out_op}, 32'h33);
      check("t3_hold_a", bus.out_a, 32'hDEAD);
      check("t3_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("t3_release", {31'd0, bus.in_ready}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    check("t3_b2b_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t3_b2b_op", {24'd0, bus.out_op}, 32'h44);
    check("t3_b2b_b", bus.out_b, 32'hB);
    tick();

    // Set wins over a same-cycle writeback clear on r7.
    drive(1'b1, 8'h55, 4'd0, 4'd0, 4'd7, 1'b1);
    tick();
    drive(1'b1, 8'h66, 4'd0, 4'd0, 4'd7, 1'b1);
    wb(1'b1, 4'd7, 32'h77);
    #1;
    check("t4_waw_fwd", {31'd0, bus.in_ready}, 32'd1);
    tick();
    wb(1'b0, 4'd0, 32'd0);
    drive(1'b1, 8'h77, 4'd7, 4'd0, 4'd0, 1'b0);
    #1;
    check("t4_set_wins", {31'd0, bus.stall}, 32'd1);
    wb(1'b1, 4'd7, 32'h777);
    tick();
    wb(1'b0, 4'd0, 32'd0);
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    check("t4_fwd_a", bus.out_a, 32'h777);
    tick();

    // Flush kills a held r9 writer and releases its pending bit.
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h88, 4'd0, 4'd0, 4'd9, 1'b1);
    tick();
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("t5_flush_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.flush = 1'b0;
    check("t5_killed", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b1, 8'h99, 4'd9, 4'd0, 4'd0, 1'b0);
    #1;
    check("t5_no_stall", {31'd0, bus.stall}, 32'd0);
    check("t5_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    check("t5_issue", {24'd0, bus.out_op}, 32'h99);
    bus.out_ready = 1'b1;
    tick();

    // Reset mid-stall discards everything.
    drive(1'b1, 8'hAA, 4'd0, 4'd0, 4'd4, 1'b1);
    tick();
    drive(1'b1, 8'hBB, 4'd4, 4'd0, 4'd0, 1'b0);
    #1;
    check("t6_stall", {31'd0, bus.stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_rst_op", {24'd0, bus.out_op}, 32'd0);
    check("t6_rst_dst", {27'd0, bus.out_dst, bus.out_dst_wr}, 32'd0);
    check("t6_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t6_rst_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_post_stall", {31'd0, bus.stall}, 32'd0);
    check("t6_post_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
    check("t6_issue_op", {24'd0, bus.out_op}, 32'hBB);
    check("t6_issue_a", bus.out_a, 32'h104);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
